uxa_ps2_rxq: RTL

PS/2 receive queue for the UXA keyboard/mouse port: write-sequencing logic plus a parametrised circular FIFO in one block. It accepts completed frames from the PS/2 deserializer, stores them, resets the deserializer for the next frame, and presents first-word-fall-through data to the CPU bus side. Over the fixed 8-bit, unflagged write logic it adds parametrised width and depth, full/almost-full status, overrun detection with a sticky flag, and a read port.

---
 rtl/uxa_ps2_rxq.sv | 84 ++++++++
 1 files changed

// File: rtl/uxa_ps2_rxq.sv
// PS/2 receive queue: sequences deserializer frames into a circular FIFO and
// presents first-word-fall-through data, with full/almost-full and sticky overrun.
module uxa_ps2_rxq #(
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 4,
  parameter int AFULL_LVL  = 12
) (
  input  logic                  sys_clk_i,
  input  logic                  sys_reset_i,
  input  logic                  frame_i,
  input  logic [DATA_W-1:0]     dat_i,
  output logic                  deser_reset_o,
  output logic                  we_o,
  output logic                  ptr_inc_o,
  input  logic                  rd_i,
  output logic [DATA_W-1:0]     dat_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic                  afull_o,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic                  overrun_o,
  input  logic                  ovr_clr_i
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {IDLE, WRITE, BUMP} state_t;

  state_t            state, state_nxt;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic              drop;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              pop;

  always_comb begin
    state_nxt     = state;
    we_o          = 1'b0;
    deser_reset_o = 1'b0;
    ptr_inc_o     = 1'b0;
    case (state)
      IDLE:    if (frame_i) state_nxt = WRITE;
      WRITE: begin
        we_o      = ~full_o;
        state_nxt = BUMP;
      end
      BUMP: begin
        deser_reset_o = 1'b1;
        ptr_inc_o     = ~drop;
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign empty_o = (wr_ptr == rd_ptr);
  assign full_o  = (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]) && (wr_ptr[PW-1] != rd_ptr[PW-1]);
  assign count_o = wr_ptr - rd_ptr;
  assign afull_o = (count_o >= PW'(AFULL_LVL));
  assign pop     = rd_i && !empty_o;
  assign dat_o   = mem[rd_ptr[PW-2:0]];

  always_ff @(posedge sys_clk_i) begin
    if (sys_reset_i) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      drop      <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == WRITE) drop <= full_o;
      if (ptr_inc_o) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      // a drop in BUMP wins over a same-cycle clear
      if (state == BUMP && drop) overrun_o <= 1'b1;
      else if (ovr_clr_i)        overrun_o <= 1'b0;
    end
  end

  // storage is never reset; a write aborted by reset is simply not committed
  always_ff @(posedge sys_clk_i) begin
    if (we_o && !sys_reset_i) mem[wr_ptr[PW-2:0]] <= dat_i;
  end
endmodule
